vc_link_arbiter: RTL and testbench

VC_LINK_ARBITER -- requirements
Module: vc_link_arbiter

---
 rtl/vc_link_arbiter_pkg.sv | 26 ++
 rtl/vc_link_arbiter_if.sv | 31 +++
 rtl/vc_link_arbiter_rr_arbiter.sv | 35 +++
 rtl/vc_link_arbiter.sv | 151 +++++++++++++++
 tb/tb_vc_link_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_link_arbiter_pkg.sv
// Shared constants and types for the virtual-channel link arbiter.
package vc_link_arbiter_pkg;

  localparam int unsigned NVc   = 4;
  localparam int unsigned FlitW = 34;
  localparam int unsigned VcIdW = $clog2(NVc);

  // Flit type lives in the top two bits of every flit.
  typedef enum logic [1:0] {
    FtHead   = 2'b00,
    FtBody   = 2'b01,
    FtSingle = 2'b10,
    FtTail   = 2'b11
  } flit_type_e;

  typedef enum logic {
    StIdle,
    StLocked
  } state_e;

  // A packet may only be opened by a HEAD or SINGLE flit.
  function automatic logic is_pkt_start(input logic [1:0] ftype);
    return (ftype == FtHead) || (ftype == FtSingle);
  endfunction

endpackage

// File: rtl/vc_link_arbiter_if.sv
// Handshake bundle between the VC buffers, the arbiter and the output link.
interface vc_link_arbiter_if import vc_link_arbiter_pkg::*; #(
  parameter int unsigned N_VC   = NVc,
  parameter int unsigned FLIT_W = FlitW
);

  localparam int unsigned IdW = $clog2(N_VC);

  logic [N_VC-1:0]        vc_valid_i;
  logic [N_VC*FLIT_W-1:0] vc_fdata_i;
  logic [N_VC-1:0]        vc_ready_o;
  logic [FLIT_W-1:0]      fdata_o;
  logic [IdW-1:0]         vc_id_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   locked_o;
  logic                   err_o;

  // Arbiter side.
  modport slave (
    input  vc_valid_i, vc_fdata_i, ready_i,
    output vc_ready_o, fdata_o, vc_id_o, valid_o, locked_o, err_o
  );

  // Environment side (VC buffers plus output link).
  modport master (
    output vc_valid_i, vc_fdata_i, ready_i,
    input  vc_ready_o, fdata_o, vc_id_o, valid_o, locked_o, err_o
  );

endinterface

// File: rtl/vc_link_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module vc_link_arbiter_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] sel;

  // Scan from the pointer upward; ptr_i + i < 2N so a single subtract wraps it.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    sum         = '0;
    sel         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (sum >= (IdxW + 1)'(N)) begin
        sum = sum - (IdxW + 1)'(N);
      end
      sel = sum[IdxW-1:0];
      if (!gnt_valid_o && req_i[sel]) begin
        gnt_o[sel]  = 1'b1;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_link_arbiter.sv
// Packet-level arbiter: multiplexes N_VC flit streams onto one registered output link,
// holding the link for a whole HEAD..TAIL packet and rotating between VCs per packet.
module vc_link_arbiter import vc_link_arbiter_pkg::*; #(
  parameter int unsigned N_VC   = NVc,
  parameter int unsigned FLIT_W = FlitW
) (
  input logic                clk,
  input logic                arst,
  vc_link_arbiter_if.slave   bus
);

  localparam int unsigned IdW = $clog2(N_VC);

  state_e             state_q, state_d;
  logic [IdW-1:0]     lock_vc_q, lock_vc_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [FLIT_W-1:0]  fdata_q, fdata_d;
  logic [IdW-1:0]     vc_id_q, vc_id_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [N_VC-1:0]    is_start;
  logic [N_VC-1:0]    req;
  logic [N_VC-1:0]    gnt;
  logic               gnt_valid;
  logic               slot_free;
  logic [N_VC-1:0]    vc_ready;
  logic               xfer;
  logic [IdW-1:0]     xfer_idx;
  logic [FLIT_W-1:0]  xfer_flit;
  logic [1:0]         xfer_type;

  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] idx);
    return (idx == IdW'(N_VC - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Classify each head-of-queue flit and build the request vector for this state.
  always_comb begin
    is_start = '0;
    for (int unsigned k = 0; k < N_VC; k++) begin
      is_start[k] = is_pkt_start(bus.vc_fdata_i[k*FLIT_W + FLIT_W - 2 +: 2]);
    end
    if (state_q == StIdle) begin
      req = bus.vc_valid_i & is_start;
    end else begin
      // Locked: only the owning VC may request, whatever it presents.
      req = bus.vc_valid_i & (N_VC'(1) << lock_vc_q);
    end
  end

  vc_link_arbiter_rr_arbiter #(
    .N (N_VC)
  ) u_rr_arbiter (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  // Pop strobes and selection of the transferred flit.
  always_comb begin
    slot_free = !valid_q || bus.ready_i;
    // Reset forces pops low even though the empty output slot looks free.
    vc_ready  = (slot_free && gnt_valid && arst) ? gnt : '0;
    xfer      = |vc_ready;
    xfer_idx  = '0;
    for (int unsigned k = 0; k < N_VC; k++) begin
      if (vc_ready[k]) begin
        xfer_idx = IdW'(k);
      end
    end
    xfer_flit = bus.vc_fdata_i[xfer_idx*FLIT_W +: FLIT_W];
    xfer_type = xfer_flit[FLIT_W-1 -: 2];
  end

  // Next-state for the packet FSM, output register and sticky error.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    fdata_d   = fdata_q;
    vc_id_d   = vc_id_q;
    valid_d   = valid_q;
    err_d     = err_q;

    if (xfer) begin
      fdata_d = xfer_flit;
      vc_id_d = xfer_idx;
      valid_d = 1'b1;
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // A BODY/TAIL at a head of queue while idle means a packet lost its HEAD.
        if (|(bus.vc_valid_i & ~is_start)) begin
          err_d = 1'b1;
        end
        if (xfer) begin
          if (xfer_type == FtHead) begin
            state_d   = StLocked;
            lock_vc_d = xfer_idx;
          end else begin
            rr_ptr_d = wrap_inc(xfer_idx);
          end
        end
      end
      StLocked: begin
        if (xfer) begin
          if (xfer_type == FtTail) begin
            state_d  = StIdle;
            rr_ptr_d = wrap_inc(lock_vc_q);
          end else if (xfer_type != FtBody) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= StIdle;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
      fdata_q   <= '0;
      vc_id_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
      fdata_q   <= fdata_d;
      vc_id_q   <= vc_id_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.vc_ready_o = vc_ready;
  assign bus.fdata_o    = fdata_q;
  assign bus.vc_id_o    = vc_id_q;
  assign bus.valid_o    = valid_q;
  assign bus.locked_o   = (state_q == StLocked);
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Randomised and directed bench for vc_link_arbiter with a packet-level reference model
// and an output scoreboard checked by an independent monitor.
module tb_vc_link_arbiter;
  import vc_link_arbiter_pkg::*;

  localparam int unsigned N  = NVc;
  localparam int unsigned W  = FlitW;
  localparam int unsigned IW = $clog2(NVc);

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  vc_link_arbiter_if #(.N_VC(N), .FLIT_W(W)) bus ();

  vc_link_arbiter #(
    .N_VC   (N),
    .FLIT_W (W)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-VC flit sources and the expected output stream.
  logic [W-1:0]    src [N][$];
  logic [IW+W-1:0] sb [$];

  // Reference model: packet ownership, rotation pointer, output slot, error flag.
  bit m_locked;
  int m_lock_vc;
  int m_rr;
  bit m_valid;
  bit m_err;

  // Decision taken before the coming edge.
  bit p_xfer;
  int p_k;
  bit p_ready;
  bit p_bad_idle;

  logic [N-1:0]   cur_v;
  logic [N*W-1:0] cur_d;
  logic           cur_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] t);
    return {t, (W-2)'($urandom)};
  endfunction

  task automatic add_pkt(input int k, input int nbody, input bit single);
    if (single) begin
      src[k].push_back(mk(2'b10));
    end else begin
      src[k].push_back(mk(2'b00));
      for (int i = 0; i < nbody; i++) src[k].push_back(mk(2'b01));
      src[k].push_back(mk(2'b11));
    end
  endtask

  task automatic add_rand_pkt(input int k);
    add_pkt(k, $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stalled.
  task automatic drive(input int ready_mode, input bit gaps);
    cur_v = '0;
    cur_d = '0;
    for (int k = 0; k < N; k++) begin
      if (src[k].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        cur_v[k] = 1'b1;
        cur_d[k*W +: W] = src[k][0];
      end
    end
    cur_r = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.vc_valid_i = cur_v;
    bus.vc_fdata_i = cur_d;
    bus.ready_i    = cur_r;
  endtask

  task automatic decide_and_check();
    int g;
    logic [1:0] t;
    logic [N-1:0] exp_rdy;
    g = -1;
    p_bad_idle = 1'b0;
    if (!m_locked) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        t = cur_d[k*W + W - 2 +: 2];
        if (cur_v[k] && (t == 2'b01 || t == 2'b11)) p_bad_idle = 1'b1;
        if (g < 0 && cur_v[k] && (t == 2'b00 || t == 2'b10)) g = k;
      end
    end else if (cur_v[m_lock_vc]) begin
      g = m_lock_vc;
    end
    exp_rdy = '0;
    if (g >= 0 && (!m_valid || cur_r)) exp_rdy[g] = 1'b1;
    check("vc_ready", bus.vc_ready_o, exp_rdy);
    check("valid", bus.valid_o, m_valid);
    check("locked", bus.locked_o, m_locked);
    check("err", bus.err_o, m_err);
    p_xfer  = (exp_rdy != 0);
    p_k     = g;
    p_ready = cur_r;
    if (p_xfer) sb.push_back({IW'(g), src[g][0]});
  endtask

  task automatic commit();
    logic [W-1:0] f;
    logic [1:0]   t;
    if (p_bad_idle) m_err = 1'b1;
    if (p_xfer) begin
      f = src[p_k].pop_front();
      t = f[W-1 -: 2];
      m_valid = 1'b1;
      if (!m_locked) begin
        if (t == 2'b00) begin
          m_locked  = 1'b1;
          m_lock_vc = p_k;
        end else begin
          m_rr = (p_k + 1) % N;
        end
      end else if (t == 2'b11) begin
        m_locked = 1'b0;
        m_rr     = (m_lock_vc + 1) % N;
      end else if (t != 2'b01) begin
        m_err = 1'b1;
      end
    end else if (p_ready) begin
      m_valid = 1'b0;
    end
    p_xfer     = 1'b0;
    p_bad_idle = 1'b0;
  endtask

  // One clock: drive after the edge, check settled outputs, update the model past the edge.
  task automatic step(input int ready_mode, input bit gaps);
    drive(ready_mode, gaps);
    #1;
    decide_and_check();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic do_reset();
    arst = 1'b0;
    #1;
    check("rst_valid", bus.valid_o, 0);
    check("rst_fdata", bus.fdata_o, 0);
    check("rst_vc_id", bus.vc_id_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_locked", bus.locked_o, 0);
    check("rst_vc_ready", bus.vc_ready_o, 0);
    for (int k = 0; k < N; k++) src[k].delete();
    sb.delete();
    m_locked = 0; m_lock_vc = 0; m_rr = 0; m_valid = 0; m_err = 0;
    p_xfer = 0; p_bad_idle = 0;
    bus.vc_valid_i = '0;
    bus.vc_fdata_i = '0;
    bus.ready_i    = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      bit busy;
      busy = m_valid || (sb.size() > 0);
      for (int k = 0; k < N; k++) if (src[k].size() > 0) busy = 1'b1;
      if (!busy) break;
      step(0, 0);
    end
    check("drain_sources_empty", src[0].size() + src[1].size() + src[2].size() + src[3].size(), 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  // Output monitor: every link handshake must match the next expected flit, and a stalled
  // flit must not change.
  logic [IW+W-1:0] mon_exp;
  logic [IW+W-1:0] mon_prev;
  bit              mon_hold = 1'b0;

  always @(negedge clk) begin
    if (!arst) begin
      mon_hold = 1'b0;
    end else begin
      if (mon_hold) check("stall_hold", {bus.vc_id_o, bus.fdata_o}, mon_prev);
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got vc %0d flit %0h with nothing expected at %0t",
                   bus.vc_id_o, bus.fdata_o, $time);
        end else begin
          mon_exp = sb.pop_front();
          check("out_flit", {bus.vc_id_o, bus.fdata_o}, mon_exp);
        end
      end
      mon_hold = bus.valid_o && !bus.ready_i;
      mon_prev = {bus.vc_id_o, bus.fdata_o};
    end
  end

  initial begin
    bus.vc_valid_i = '0;
    bus.vc_fdata_i = '0;
    bus.ready_i    = 1'b0;
    #2;
    do_reset();

    // Single packet on VC0, back-to-back.
    add_pkt(0, 1, 0);
    repeat (6) step(0, 0);

    // VC1 and VC2 heads from pointer 0: VC1 packet completes first.
    do_reset();
    add_pkt(1, 3, 0);
    add_pkt(2, 2, 0);
    repeat (14) step(0, 0);

    // VC3 head waits out a long VC0 packet.
    do_reset();
    add_pkt(0, 4, 0);
    add_pkt(3, 1, 0);
    repeat (14) step(0, 0);

    // Link stall for five cycles mid-packet.
    add_pkt(1, 3, 0);
    repeat (2) step(0, 0);
    repeat (5) step(2, 0);
    repeat (10) step(0, 0);

    // Pointer to 3 via a VC2 single, then singles on VC3 and VC0, then heads on VC1/VC2.
    do_reset();
    add_pkt(2, 0, 1);
    repeat (3) step(0, 0);
    add_pkt(3, 0, 1);
    add_pkt(0, 0, 1);
    repeat (4) step(0, 0);
    add_pkt(2, 1, 0);
    add_pkt(1, 1, 0);
    repeat (10) step(0, 0);
    drain();

    // Random traffic with bubbles on both sides.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (src[k].size() == 0 && $urandom_range(0, 5) == 0) add_rand_pkt(k);
      end
      step(1, 1);
    end
    drain();

    // Orphan TAIL while idle raises the sticky error and is never granted.
    do_reset();
    src[2].push_back(mk(2'b11));
    repeat (4) step(0, 0);
    check("err_sticky", bus.err_o, 1);

    // Reset in the middle of a packet, then restart from VC0.
    do_reset();
    add_pkt(0, 3, 0);
    repeat (2) step(0, 0);
    bus.vc_valid_i = 4'b0001;
    do_reset();
    add_pkt(1, 1, 0);
    add_pkt(0, 1, 0);
    repeat (10) step(0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
